// File: rtl/filter_loader_if.sv
// -----------------------------------------------------------------------------
// filter_loader_if
// Bundles the three buses around the filter loader:
//   control side : start, base_addr, num_rows in; busy, done, err out
//   memory side  : mem_rd_en, mem_addr out; mem_rdata in (1-cycle read latency)
//   buffer side  : buff_ld, buff_row, buff_data out
// slave  : the loader itself
// master : whatever surrounds it (controller + filter memory + filter buffer)
// -----------------------------------------------------------------------------
interface filter_loader_if #(
    parameter int ADDR_W = 16
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        num_rows;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              buff_ld;
    logic [1:0]        buff_row;
    logic [31:0]       buff_data;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, base_addr, num_rows, mem_rdata,
        output mem_rd_en, mem_addr, buff_ld, buff_row, buff_data, busy, done, err
    );

    modport master (
        output start, base_addr, num_rows, mem_rdata,
        input  mem_rd_en, mem_addr, buff_ld, buff_row, buff_data, busy, done, err
    );
endinterface

// File: rtl/filter_loader.sv
// -----------------------------------------------------------------------------
// filter_loader
// Writer-side sequencer for the 4x4 byte filter buffer. On an accepted start it
// reads num_rows consecutive 32-bit words from the filter memory starting at
// base_addr, and loads each returned word into the next buffer row, one row per
// cycle. done pulses once the last row is in; err pulses on a start request
// whose row count is out of range.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; aborts any transfer in progress
//   bus  : filter_loader_if.slave
//          start/base_addr/num_rows  - load request (sampled only in IDLE)
//          mem_rd_en/mem_addr        - registered memory read strobe/address
//          mem_rdata                 - read data, valid the cycle after the strobe
//          buff_ld/buff_row          - registered buffer row-load strobe/index
//          buff_data                 - straight from mem_rdata
//          busy/done/err             - status
//
// Timing for an N-row load whose start is sampled at edge E0:
//   reads in cycles 1..N, loads in cycles 2..N+1, done in cycle N+2,
//   busy in cycles 1..N+1.
// -----------------------------------------------------------------------------
module filter_loader #(
    parameter int ADDR_W   = 16,
    parameter int MAX_ROWS = 4
) (
    input  logic            clk,
    input  logic            rst,
    filter_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FIN
    } state_t;

    localparam logic [2:0] MAX_N = 3'(MAX_ROWS);

    state_t            state;
    logic [ADDR_W-1:0] base_q;   // captured base address
    logic [2:0]        num_q;    // captured row count
    logic [2:0]        rd_cnt;   // reads issued so far in this transfer
    logic [1:0]        rd_row;   // row index of the read currently on the bus

    // Memory data goes to the buffer unregistered: the read latency already
    // lines it up with the delayed buff_ld/buff_row.
    assign bus.buff_data = bus.mem_rdata;

    // NOTE: every register here is updated with non-blocking assignments so
    // that all right-hand sides see the pre-edge values; this is what makes
    // buff_ld/buff_row an exact one-cycle delay of mem_rd_en/rd_row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base_q        <= '0;
            num_q         <= '0;
            rd_cnt        <= '0;
            rd_row        <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.buff_ld   <= 1'b0;
            bus.buff_row  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;

            // Load stage trails the read stage by the memory latency.
            bus.buff_ld  <= bus.mem_rd_en;
            bus.buff_row <= rd_row;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_rows != 3'd0 && bus.num_rows <= MAX_N) begin
                            // Issue row 0 right away so the first read lands
                            // in cycle 1.
                            base_q        <= bus.base_addr;
                            num_q         <= bus.num_rows;
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= bus.base_addr;
                            rd_row        <= 2'd0;
                            rd_cnt        <= 3'd1;
                            bus.busy      <= 1'b1;
                            state         <= FETCH;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    if (rd_cnt < num_q) begin
                        // Address arithmetic wraps at 2^ADDR_W.
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= base_q + ADDR_W'(rd_cnt);
                        rd_row        <= rd_cnt[1:0];
                        rd_cnt        <= rd_cnt + 3'd1;
                    end else begin
                        bus.mem_rd_en <= 1'b0;
                        state         <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Final load is on the bus this cycle.
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= FIN;
                end

                FIN: begin
                    // done is high here; start is deliberately not sampled.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_loader.sv
// -----------------------------------------------------------------------------
// tb_filter_loader
// Drives load requests, models the 1-cycle-latency filter memory, and checks
// every read address and every buffer load against a scoreboard filled when the
// request is driven. Cycle-level status (busy/done/err/strobes) is checked per
// cycle relative to the start edge.
// -----------------------------------------------------------------------------
module tb_filter_loader;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [1:0]  row;
        logic [31:0] data;
    } load_t;

    logic clk;
    logic rst;

    filter_loader_if #(.ADDR_W(ADDR_W)) bus ();

    filter_loader #(
        .ADDR_W   (ADDR_W),
        .MAX_ROWS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [ADDR_W-1:0] rd_q[$];
    load_t             ld_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Filter memory contents: fixed words for the full-load rows, a
    // address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        case (a)
            16'h0010: mem_word = 32'h01020304;
            16'h0011: mem_word = 32'h05060708;
            16'h0012: mem_word = 32'h090A0B0C;
            16'h0013: mem_word = 32'h0D0E0F10;
            default:  mem_word = {~a, a};
        endcase
    endfunction

    // Memory model with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rdata <= mem_word(bus.mem_addr);
    end

    // Output monitor: compares every read and every load with the scoreboard.
    always @(negedge clk) begin
        if (bus.mem_rd_en) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0)
                check("mem_addr", 32'(bus.mem_addr), 32'(rd_q.pop_front()));
        end
        if (bus.buff_ld) begin
            check("ld_expected", 32'(ld_q.size() != 0), 32'd1);
            if (ld_q.size() != 0) begin
                load_t e;
                e = ld_q.pop_front();
                check("buff_row", 32'(bus.buff_row), 32'(e.row));
                check("buff_data", bus.buff_data, e.data);
            end
        end
    end

    // Called at a negedge: drives start, then checks cycles 1..n+3.
    // With ign set, extra starts carrying other parameters are pulsed in
    // cycle 2 and in the done cycle; both must be ignored.
    task automatic xfer(input logic [ADDR_W-1:0] base, input int n, input bit ign);
        for (int k = 0; k < n; k++) begin
            logic [ADDR_W-1:0] a;
            load_t e;
            a = base + ADDR_W'(k);
            rd_q.push_back(a);
            e.row  = 2'(k);
            e.data = mem_word(a);
            ld_q.push_back(e);
        end
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_rows  = 3'(n);
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            check("busy",  32'(bus.busy),      32'(c <= n + 1));
            check("done",  32'(bus.done),      32'(c == n + 2));
            check("rd_en", 32'(bus.mem_rd_en), 32'(c <= n));
            check("ld",    32'(bus.buff_ld),   32'(c >= 2 && c <= n + 1));
            check("err",   32'(bus.err),       32'd0);
            // Captured inputs must not track later changes.
            bus.start     = 1'b0;
            bus.base_addr = ~base;
            bus.num_rows  = 3'd1;
            if (ign && (c == 2 || c == n + 2)) begin
                bus.start     = 1'b1;
                bus.base_addr = 16'h0BAD;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic bad_start(input logic [2:0] n);
        bus.start    = 1'b1;
        bus.num_rows = n;
        @(negedge clk);
        bus.start = 1'b0;
        check("err_pulse", 32'(bus.err),       32'd1);
        check("err_rd",    32'(bus.mem_rd_en), 32'd0);
        check("err_busy",  32'(bus.busy),      32'd0);
        @(negedge clk);
        check("err_clear", 32'(bus.err),       32'd0);
        check("err_rd2",   32'(bus.mem_rd_en), 32'd0);
        check("err_ld",    32'(bus.buff_ld),   32'd0);
        check("err_busy2", 32'(bus.busy),      32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_ld"},    32'(bus.buff_ld),   32'd0);
        check({tag, "_row"},   32'(bus.buff_row),  32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_done"},  32'(bus.done),      32'd0);
        check({tag, "_err"},   32'(bus.err),       32'd0);
    endtask

    // 4-row load from 0x0020 with reset asserted during cycle 3.
    task automatic reset_abort();
        load_t e;
        rd_q.push_back(16'h0020);
        rd_q.push_back(16'h0021);
        rd_q.push_back(16'h0022);
        e.row = 2'd0; e.data = mem_word(16'h0020); ld_q.push_back(e);
        e.row = 2'd1; e.data = mem_word(16'h0021); ld_q.push_back(e);
        bus.start     = 1'b1;
        bus.base_addr = 16'h0020;
        bus.num_rows  = 3'd4;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("ab_rd_en", 32'(bus.mem_rd_en), 32'd1);
            check("ab_busy",  32'(bus.busy),      32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("ab_rst");
        rst = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk);
            check("ab_post_rd",   32'(bus.mem_rd_en), 32'd0);
            check("ab_post_done", 32'(bus.done),      32'd0);
            check("ab_post_busy", 32'(bus.busy),      32'd0);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        xfer(16'h0010, 4, 1'b0);   // full load, fixed data
        xfer(16'h0100, 2, 1'b0);   // partial load
        bad_start(3'd0);           // illegal sizes
        bad_start(3'd5);
        bad_start(3'd7);
        xfer(16'hFFFE, 4, 1'b0);   // address wrap
        xfer(16'h0040, 3, 1'b1);   // starts outside IDLE ignored
        reset_abort();
        xfer(16'h0200, 1, 1'b0);   // single row after abort
        xfer(16'h0300, 4, 1'b0);

        check("rd_q_left", 32'(rd_q.size()), 32'd0);
        check("ld_q_left", 32'(ld_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
